// File: rtl/updown_mod_counter_if.sv
// Control/status bundle for updown_mod_counter: the master drives counting
// controls and the slave (the counter) returns its count and event flags.
interface updown_mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic             LOAD;
  logic             UP;
  logic             DOWN;
  logic             MODE;
  logic [WIDTH-1:0] IN;
  logic [WIDTH-1:0] MAX;
  logic [WIDTH-1:0] STEP;
  logic [WIDTH-1:0] OUT;
  logic             CARRY;
  logic             BORROW;
  logic             AT_MAX;
  logic             AT_ZERO;

  modport master (
    output EN, LOAD, UP, DOWN, MODE, IN, MAX, STEP,
    input  OUT, CARRY, BORROW, AT_MAX, AT_ZERO
  );

  modport slave (
    input  EN, LOAD, UP, DOWN, MODE, IN, MAX, STEP,
    output OUT, CARRY, BORROW, AT_MAX, AT_ZERO
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down counter over the range 0..MAX with programmable step, wrap or
// saturate behaviour, and registered one-cycle CARRY/BORROW event pulses.
module updown_mod_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                 CLK,
  input logic                 RST_N,
  updown_mod_counter_if.slave bus
);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  logic [WIDTH-1:0] out_reg, out_next;
  logic             carry_reg, carry_next;
  logic             borrow_reg, borrow_next;

  // Arithmetic is carried one bit wider so MAX+1 and OUT+STEP never overflow.
  logic [WIDTH:0]   out_ext, max_ext, mod_ext, step_ext, step_eff, sum_ext;
  logic [WIDTH-1:0] up_val, dn_val, wrap_up_val, wrap_dn_val, load_val;
  logic             up_ovf, dn_unf;

  assign out_ext     = {1'b0, out_reg};
  assign max_ext     = {1'b0, bus.MAX};
  assign mod_ext     = max_ext + ONE_EXT;
  assign step_ext    = {1'b0, bus.STEP};
  assign step_eff    = (step_ext > mod_ext) ? mod_ext : step_ext;
  assign sum_ext     = out_ext + step_eff;
  assign up_ovf      = sum_ext > max_ext;
  assign dn_unf      = out_ext < step_eff;
  assign up_val      = WIDTH'(sum_ext);
  assign dn_val      = WIDTH'(out_ext - step_eff);
  assign wrap_up_val = WIDTH'(sum_ext - mod_ext);
  assign wrap_dn_val = WIDTH'(out_ext + mod_ext - step_eff);
  assign load_val    = (bus.IN > bus.MAX) ? bus.MAX : bus.IN;

  always_comb begin
    out_next    = out_reg;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    if (bus.LOAD) begin
      out_next = load_val;
    end else if (bus.EN) begin
      // A lowered MAX pulls the count back into range before any counting.
      if (out_reg > bus.MAX) begin
        out_next = bus.MAX;
      end else if (bus.UP && !bus.DOWN) begin
        if (up_ovf) begin
          out_next   = bus.MODE ? bus.MAX : wrap_up_val;
          carry_next = 1'b1;
        end else begin
          out_next = up_val;
        end
      end else if (bus.DOWN && !bus.UP) begin
        if (dn_unf) begin
          out_next    = bus.MODE ? '0 : wrap_dn_val;
          borrow_next = 1'b1;
        end else begin
          out_next = dn_val;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_reg    <= RESET_VAL;
      carry_reg  <= 1'b0;
      borrow_reg <= 1'b0;
    end else begin
      out_reg    <= out_next;
      carry_reg  <= carry_next;
      borrow_reg <= borrow_next;
    end
  end

  assign bus.OUT     = out_reg;
  assign bus.CARRY   = carry_reg;
  assign bus.BORROW  = borrow_reg;
  assign bus.AT_MAX  = (out_reg == bus.MAX);
  assign bus.AT_ZERO = (out_reg == '0);
endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: directed vector table, asynchronous reset
// sequence, then randomized traffic against an arithmetic reference model.
module tb_updown_mod_counter;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  updown_mod_counter_if #(.WIDTH(W)) bus ();

  updown_mod_counter #(.WIDTH(W), .RESET_VAL('0)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit en, load, up, down, mode;
    int in_v, max_v, step_v;
    int e_out;
    bit e_c, e_b, e_am, e_az;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(bit en, bit load, bit up, bit down, bit mode,
                                  int in_v, int max_v, int step_v,
                                  int e_out, bit e_c, bit e_b, bit e_am, bit e_az);
    vec_t v;
    v.en = en; v.load = load; v.up = up; v.down = down; v.mode = mode;
    v.in_v = in_v; v.max_v = max_v; v.step_v = step_v;
    v.e_out = e_out; v.e_c = e_c; v.e_b = e_b; v.e_am = e_am; v.e_az = e_az;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input int exp_v);
    checks++;
    if (act !== 32'(exp_v)) begin
      failures++;
      $display("FAIL %s #%0d: got %0d, expected %0d", name, idx, act, exp_v);
    end
  endtask

  task automatic drive(input bit en, input bit load, input bit up, input bit down, input bit mode,
                       input int in_v, input int max_v, input int step_v);
    bus.EN   = en;
    bus.LOAD = load;
    bus.UP   = up;
    bus.DOWN = down;
    bus.MODE = mode;
    bus.IN   = W'(in_v);
    bus.MAX  = W'(max_v);
    bus.STEP = W'(step_v);
  endtask

  task automatic check_all(input string tag, input int idx, input int e_out,
                           input bit e_c, input bit e_b, input bit e_am, input bit e_az);
    check({tag, ".out"},     idx, 32'(bus.OUT),     e_out);
    check({tag, ".carry"},   idx, 32'(bus.CARRY),   int'(e_c));
    check({tag, ".borrow"},  idx, 32'(bus.BORROW),  int'(e_b));
    check({tag, ".at_max"},  idx, 32'(bus.AT_MAX),  int'(e_am));
    check({tag, ".at_zero"}, idx, 32'(bus.AT_ZERO), int'(e_az));
  endtask

  // Reference model: counts over the ring 0..MAX using modular arithmetic.
  int m_out;
  bit m_c, m_b;

  function automatic void model_step(bit en, bit load, bit up, bit down, bit mode,
                                     int in_v, int max_v, int step_v);
    int m, s;
    m   = max_v + 1;
    s   = (step_v < m) ? step_v : m;
    m_c = 1'b0;
    m_b = 1'b0;
    if (load) begin
      m_out = (in_v < max_v) ? in_v : max_v;
    end else if (en) begin
      if (m_out > max_v) begin
        m_out = max_v;
      end else if (up && !down) begin
        if (m_out + s > max_v) begin
          m_c   = 1'b1;
          m_out = mode ? max_v : (m_out + s) % m;
        end else begin
          m_out = m_out + s;
        end
      end else if (down && !up) begin
        if (s > m_out) begin
          m_b   = 1'b1;
          m_out = mode ? 0 : (m_out - s + m) % m;
        end else begin
          m_out = m_out - s;
        end
      end
    end
  endfunction

  initial begin
    // en ld up dn md  in max stp | out  c  b am az
    add_vec(1,1,0,0,0,  8, 9, 3,   8, 0,0,0,0);   // wrap up
    add_vec(1,0,1,0,0,  0, 9, 3,   1, 1,0,0,0);
    add_vec(1,0,0,0,0,  0, 9, 3,   1, 0,0,0,0);
    add_vec(1,0,1,0,0,  0, 9, 3,   4, 0,0,0,0);
    add_vec(1,0,1,0,0,  0, 9, 3,   7, 0,0,0,0);
    add_vec(1,1,0,0,0,  9, 9, 3,   9, 0,0,1,0);
    add_vec(1,1,0,0,1,  2, 9, 3,   2, 0,0,0,0);   // saturate down
    add_vec(1,0,0,1,1,  0, 9, 3,   0, 0,1,0,1);
    add_vec(1,0,0,1,1,  0, 9, 3,   0, 0,1,0,1);
    add_vec(1,0,0,0,1,  0, 9, 3,   0, 0,0,0,1);
    add_vec(0,1,0,0,0, 12, 9, 3,   9, 0,0,1,0);   // load above MAX, EN=0
    add_vec(1,0,0,0,0,  0, 5, 3,   5, 0,0,1,0);   // clamp
    add_vec(1,1,0,0,0,  9, 9, 3,   9, 0,0,1,0);
    add_vec(1,0,1,0,0,  0, 5, 3,   5, 0,0,1,0);   // clamp beats count
    add_vec(1,1,0,0,0,  4, 9, 3,   4, 0,0,0,0);   // conflicts / enable
    add_vec(1,0,1,1,0,  0, 9, 3,   4, 0,0,0,0);
    add_vec(0,0,1,0,0,  0, 9, 3,   4, 0,0,0,0);
    add_vec(1,0,1,0,0,  0, 9, 0,   4, 0,0,0,0);
    add_vec(1,0,0,1,0,  0, 9, 0,   4, 0,0,0,0);
    add_vec(1,1,0,0,0,  9, 9, 3,   9, 0,0,1,0);
    add_vec(0,0,0,0,0,  0, 5, 3,   9, 0,0,0,0);   // no clamp while disabled
    add_vec(1,1,0,0,1,  8, 9, 3,   8, 0,0,0,0);   // saturate up repeats
    add_vec(1,0,1,0,1,  0, 9, 3,   9, 1,0,1,0);
    add_vec(1,0,1,0,1,  0, 9, 3,   9, 1,0,1,0);
    add_vec(1,0,0,0,1,  0, 9, 3,   9, 0,0,1,0);
    add_vec(1,1,0,0,0,  5, 0, 1,   0, 0,0,1,1);   // MAX=0
    add_vec(1,0,1,0,0,  0, 0, 1,   0, 1,0,1,1);
    add_vec(1,0,0,1,0,  0, 0, 1,   0, 0,1,1,1);
    add_vec(1,1,0,0,0,  3, 9,15,   3, 0,0,0,0);   // STEP larger than MAX+1
    add_vec(1,0,1,0,0,  0, 9,15,   3, 1,0,0,0);
    add_vec(1,0,0,1,0,  0, 9,15,   3, 0,1,0,0);
    add_vec(1,0,1,0,0,  0, 9,15,   3, 1,0,0,0);
    add_vec(1,1,0,0,0,  3, 9,15,   3, 0,0,0,0);   // load clears carry
    add_vec(1,1,0,0,0, 15,15, 1,  15, 0,0,1,0);   // legacy 4-bit behaviour
    add_vec(1,0,1,0,0,  0,15, 1,   0, 1,0,0,1);
    add_vec(1,0,1,0,0,  0,15, 1,   1, 0,0,0,0);
    add_vec(1,0,1,0,0,  0,15, 1,   2, 0,0,0,0);
    add_vec(1,0,1,0,0,  0,15, 1,   3, 0,0,0,0);
    add_vec(1,0,1,0,0,  0,15, 1,   4, 0,0,0,0);
    add_vec(1,0,0,1,0,  0,15, 1,   3, 0,0,0,0);
    add_vec(1,0,0,1,0,  0,15, 1,   2, 0,0,0,0);
    add_vec(1,0,0,1,0,  0,15, 1,   1, 0,0,0,0);
    add_vec(1,0,0,1,0,  0,15, 1,   0, 0,0,0,1);
    add_vec(1,0,0,1,0,  0,15, 1,  15, 0,1,1,0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 9, 1);
    @(negedge clk);
    @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].load, vecs[i].up, vecs[i].down, vecs[i].mode,
            vecs[i].in_v, vecs[i].max_v, vecs[i].step_v);
      @(posedge clk);
      @(negedge clk);
      $display("vec %0d: out=%0d carry=%0d borrow=%0d at_max=%0d at_zero=%0d",
               i, bus.OUT, bus.CARRY, bus.BORROW, bus.AT_MAX, bus.AT_ZERO);
      check_all("vec", i, vecs[i].e_out, vecs[i].e_c, vecs[i].e_b, vecs[i].e_am, vecs[i].e_az);
    end

    // Asynchronous reset between edges while a carry pulse is live.
    drive(1, 1, 0, 0, 0, 8, 9, 3);
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 1, 0, 0, 0, 9, 3);
    @(posedge clk);
    @(negedge clk);
    $display("pre-reset: out=%0d carry=%0d", bus.OUT, bus.CARRY);
    check_all("prerst", 0, 1, 1, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: out=%0d carry=%0d", bus.OUT, bus.CARRY);
    check("rst.out", 0, 32'(bus.OUT), 0);
    check("rst.carry", 0, 32'(bus.CARRY), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 9, 3);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    $display("post-reset hold: out=%0d", bus.OUT);
    check_all("postrst", 0, 0, 0, 0, 0, 1);

    // Randomized traffic against the reference model, starting from reset.
    m_out = 0;
    begin
      bit en, load, up, down, mode;
      int in_v, max_v, step_v;
      max_v = 9;
      for (int n = 0; n < 400; n++) begin
        en   = ($urandom_range(0, 9) != 0);
        load = ($urandom_range(0, 9) == 0);
        up   = 1'($urandom_range(0, 1));
        down = 1'($urandom_range(0, 1));
        mode = 1'($urandom_range(0, 1));
        in_v = $urandom_range(0, 15);
        if ($urandom_range(0, 7) == 0) max_v = $urandom_range(0, 15);
        step_v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
        drive(en, load, up, down, mode, in_v, max_v, step_v);
        model_step(en, load, up, down, mode, in_v, max_v, step_v);
        @(posedge clk);
        @(negedge clk);
        $display("rnd %0d: en=%0d ld=%0d up=%0d dn=%0d md=%0d in=%0d max=%0d step=%0d -> out=%0d c=%0d b=%0d",
                 n, en, load, up, down, mode, in_v, max_v, step_v, bus.OUT, bus.CARRY, bus.BORROW);
        check_all("rnd", n, m_out, m_c, m_b, m_out == max_v, m_out == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down counter with programmable modulus, step size and wrap/saturate mode. It is the general-purpose replacement for the fixed 4-bit up/down counter in lab designs. Targets are timers, address generators and position counters that need a range other than 2^WIDTH. Carry and borrow pulses allow cascading and event detection.

## Interface
- WIDTH, 8, counter and data width (≥2)
- RESET_VAL, 0, value of OUT after reset; must be ≤ MAX in use
- CLK  input  1  clock, all state updates on rising edge
- RST_N  input  1  asynchronous active-low reset
- EN  input  1  count/clamp enable; LOAD is not gated by EN
- LOAD  input  1  synchronous parallel load, highest priority
- UP  input  1  count up by STEP
- DOWN  input  1  count down by STEP
- MODE  input  1  0 = wrap (modulo MAX+1), 1 = saturate at 0/MAX
- IN  input  WIDTH  load value
- MAX  input  WIDTH  terminal value; legal range is 0..MAX
- STEP  input  WIDTH  increment/decrement magnitude
- OUT  output  WIDTH  registered count
- CARRY  output  1  registered one-cycle pulse on up-overflow
- BORROW  output  1  registered one-cycle pulse on down-underflow
- AT_MAX  output  1  combinational, OUT == MAX
- AT_ZERO  output  1  combinational, OUT == 0

## Operation
- Reset (RST_N=0, asynchronous): OUT=RESET_VAL, CARRY=0, BORROW=0. Reset overrides everything, including mid-count.
- Per-edge priority:
  1. LOAD=1: OUT <= min(IN, MAX).
  2. EN=0: hold.
  3. OUT > MAX (MAX was lowered): OUT <= MAX. This clamp overrides any count.
  4. UP=1 and DOWN=1: hold.
  5. UP only: count up.
  6. DOWN only: count down.
  7. Otherwise: hold.
- Arithmetic is done at WIDTH+1 bits. M = MAX+1. S = min(STEP, M).
- Up, when OUT+S ≤ MAX: OUT <= OUT+S, no flag.
- Up, when OUT+S > MAX:
  - MODE=0: OUT <= OUT+S−M.
  - MODE=1: OUT <= MAX.
  - CARRY=1 next cycle in both modes.
- Down, when OUT ≥ S: OUT <= OUT−S, no flag.
- Down, when OUT < S:
  - MODE=0: OUT <= OUT+M−S.
  - MODE=1: OUT <= 0.
  - BORROW=1 next cycle in both modes.
- STEP=0 leaves OUT unchanged and raises no flags.
- Saturate mode keeps pulsing CARRY (or BORROW) on every further count attempt while held at MAX (or 0).
- CARRY and BORROW are cleared on every edge that does not set them. This includes LOAD, hold and clamp cycles. They are never set together.
- MAX=0 is legal: OUT stays 0. Every up or down with STEP≥1 pulses CARRY or BORROW.

## Timing
- Count, load and clamp latency: 1 cycle. OUT updates on the same edge that samples the controls.
- CARRY and BORROW are registered and assert on the same edge as the OUT update that caused them, for exactly one cycle per event.
- AT_MAX and AT_ZERO follow OUT and MAX combinationally with no extra latency.
- All control inputs are sampled only at rising CLK. Glitches between edges have no effect.
- Reset deassertion must be synchronous to CLK externally. The first count happens on the first edge with RST_N=1.

## Test plan
- Reset mid-count (WIDTH=4, counting up): drop RST_N between edges → OUT=0 and CARRY=0 immediately; after release, hold with controls low.
- Wrap up: MAX=9, STEP=3, MODE=0, OUT=8, UP one cycle → OUT=1, CARRY=1 for one cycle, then 0; AT_MAX=1 when OUT=9.
- Saturate down: MAX=9, STEP=3, MODE=1, OUT=2, DOWN two cycles → OUT=0, 0; BORROW=1 on both cycles; AT_ZERO=1.
- Load and clamp: MAX=9, LOAD with IN=12 and EN=0 → OUT=9. Then MAX=5 with EN=1, no UP/DOWN → OUT=5 next edge, no flags.
- Conflicts and enable: UP=DOWN=1 → OUT holds. EN=0 with UP=1 → OUT holds. STEP=0 with UP=1 → OUT holds, CARRY=0.
- Legacy equivalence: WIDTH=4, MAX=15, STEP=1, MODE=0, load 15, then UP 5 cycles → OUT=0,1,2,3,4 with CARRY only on the first edge. Then DOWN 5 cycles → 3,2,1,0,15 with BORROW on the last edge.
